// File: rtl/pcihellocore_hexport_multi.sv
// pcihellocore_hexport_multi
//   Multi-channel output port behind a small register slave. Each channel
//   holds a DATA word that is driven on out_port one clock after it changes.
//   With PCIHELLOCORE_HEXPORT_BLINK_EN defined, channels selected by MASK
//   alternate between DATA and BLANK_VALUE. Each half-period lasts PERIOD
//   clocks while CTRL.EN is set.
//
// Register map (word addresses):
//   0..7  DATA[n]  DATA_WIDTH bits, R/W (n >= CHANNELS: reads 0, writes dropped)
//   8     MASK     CHANNELS bits, R/W                    (blink build only)
//   9     PERIOD   24 bits, R/W; a write restarts the blink timer
//   10    CTRL     bit0 EN (R/W), bit1 RESTART (write-1 pulse, reads 0)
//   11    STATUS   RO: bit0 PHASE, bits[31:8] CNT
//   12..15         read 0
//   Without the blink build, addresses 8..15 read 0 and ignore writes.
//
// Ports:
//   clk         clock, all state on rising edge
//   reset_n     asynchronous active-low reset
//   address     register word address
//   chipselect  slave select
//   write_n     active-low write strobe (write = chipselect & ~write_n)
//   writedata   write data
//   readdata    combinational read data, zero wait states
//   out_port    registered channel outputs, channel n at [n*DATA_WIDTH +: DATA_WIDTH]
//
// Optional feature macro: PCIHELLOCORE_HEXPORT_BLINK_EN

module pcihellocore_hexport_multi #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          CHANNELS     = 2,
  parameter logic [31:0] RESET_VALUE  = 32'h40404040,
  parameter logic [31:0] BLANK_VALUE  = 32'h7F7F7F7F,
  parameter logic [23:0] PERIOD_RESET = 24'd0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [3:0]                   address,
  input  logic                         chipselect,
  input  logic                         write_n,
  input  logic [31:0]                  writedata,
  output logic [31:0]                  readdata,
  output logic [CHANNELS*DATA_WIDTH-1:0] out_port
);

  localparam logic [DATA_WIDTH-1:0] RST_D   = RESET_VALUE[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] BLANK_D = BLANK_VALUE[DATA_WIDTH-1:0];

  logic                  wr;
  logic [DATA_WIDTH-1:0] data [CHANNELS];
  logic [CHANNELS-1:0]   blank_sel;

  assign wr = chipselect & ~write_n;

  // NOTE: the channel registers form a tiny register file, not a RAM, so
  // every entry is reset; an unreset entry would leave out_port undefined.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < CHANNELS; n++) data[n] <= RST_D;
    end else if (wr && !address[3]) begin
      for (int n = 0; n < CHANNELS; n++) begin
        // NOTE: state uses non-blocking assignment so every register samples
        // pre-edge values regardless of the order the blocks are evaluated.
        if (address[2:0] == 3'(n)) data[n] <= writedata[DATA_WIDTH-1:0];
      end
    end
  end

`ifdef PCIHELLOCORE_HEXPORT_BLINK_EN
  logic [CHANNELS-1:0] mask;
  logic [23:0]         period;
  logic [23:0]         cnt;
  logic                en;
  logic                phase;
  logic                restart;

  // Both a PERIOD write and CTRL.RESTART restart the half-period from the
  // visible phase, and take priority over a wrap on the same edge.
  assign restart = wr && ((address == 4'd9) ||
                          ((address == 4'd10) && writedata[1]));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask   <= '0;
      period <= PERIOD_RESET;
      en     <= 1'b0;
    end else if (wr) begin
      case (address)
        4'd8:    mask   <= writedata[CHANNELS-1:0];
        4'd9:    period <= writedata[23:0];
        4'd10:   en     <= writedata[0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (restart || !en || (period == 24'd0)) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (cnt == period - 24'd1) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + 24'd1;
    end
  end

  assign blank_sel = mask & {CHANNELS{en & ~phase}};
`else
  assign blank_sel = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port <= {CHANNELS{RST_D}};
    end else begin
      for (int n = 0; n < CHANNELS; n++)
        out_port[n*DATA_WIDTH +: DATA_WIDTH] <= blank_sel[n] ? BLANK_D : data[n];
    end
  end

  always_comb begin
    // NOTE: default first so no path through the decode leaves readdata
    // unassigned, which would otherwise infer a latch.
    readdata = '0;
    if (!address[3]) begin
      for (int n = 0; n < CHANNELS; n++)
        if (address[2:0] == 3'(n)) readdata[DATA_WIDTH-1:0] = data[n];
    end
`ifdef PCIHELLOCORE_HEXPORT_BLINK_EN
    case (address)
      4'd8:    readdata[CHANNELS-1:0] = mask;
      4'd9:    readdata[23:0]         = period;
      4'd10:   readdata[0]            = en;
      4'd11:   readdata               = {cnt, 7'b0, phase};
      default: ;
    endcase
`endif
  end

endmodule
